// File: rtl/parity_link_pkg.sv
// Shared constants and state type for the parity link generator/checker.
package parity_link_pkg;

  localparam int unsigned PAR_EVEN = 0;
  localparam int unsigned PAR_ODD  = 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } gen_state_e;

endpackage

// File: rtl/parity_calc.sv
// XOR reduction of a word with parity-mode adjust: par = (^data) ^ ODD.
// A zero result over a full frame means the frame parity is correct.
module parity_calc
  import parity_link_pkg::*;
#(
  parameter int          W   = 8,
  parameter int unsigned ODD = PAR_EVEN
) (
  input  logic [W-1:0] data,
  output logic         par
);

  localparam bit ODD_BIT = (ODD != PAR_EVEN);

  assign par = (^data) ^ ODD_BIT;

endmodule

// File: rtl/parity_link_gen_chk.sv
// Parity frame generator (one-entry output register) and registered checker
// with sticky flag and saturating error counter.
// Build option: define PARITY_NOISE_INJ_EN to allow single-bit corruption of captured frames.
//
// state | meaning
// EMPTY | no frame held, input always accepted
// FULL  | frame held on frame_data, waiting for frame_ready
module parity_link_gen_chk
  import parity_link_pkg::*;
#(
  parameter  int          DATA_W  = 8,
  parameter  int unsigned ODD     = PAR_EVEN,
  parameter  int          CNT_W   = 8,
  localparam int          FRAME_W = DATA_W + 1,
  localparam int          IDX_W   = $clog2(FRAME_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [FRAME_W-1:0] frame_data,
  input  logic               noise_en,
  input  logic [IDX_W-1:0]   noise_idx,
  input  logic               chk_valid,
  input  logic [FRAME_W-1:0] chk_frame,
  output logic               chk_out_valid,
  output logic [DATA_W-1:0]  chk_out_data,
  output logic               chk_err,
  output logic               err_sticky,
  output logic [CNT_W-1:0]   err_cnt,
  input  logic               err_clr
);

  gen_state_e         state, state_nxt;
  logic               xfer;
  logic               gen_par;
  logic               chk_fail;
  logic               new_err;
  logic [FRAME_W-1:0] frame_nxt;

  parity_calc #(.W(DATA_W), .ODD(ODD)) u_gen_par (
    .data (in_data),
    .par  (gen_par)
  );

  parity_calc #(.W(FRAME_W), .ODD(ODD)) u_chk_par (
    .data (chk_frame),
    .par  (chk_fail)
  );

  assign in_ready    = (state == EMPTY) || frame_ready;
  assign xfer        = in_valid && in_ready;
  assign frame_valid = (state == FULL);

`ifdef PARITY_NOISE_INJ_EN
  logic [FRAME_W-1:0] noise_mask;

  // Indices at or above FRAME_W match no bit, so they inject nothing.
  always_comb begin
    noise_mask = '0;
    for (int i = 0; i < FRAME_W; i++)
      noise_mask[i] = noise_en && (noise_idx == IDX_W'(i));
  end

  assign frame_nxt = {in_data, gen_par} ^ noise_mask;
`else
  logic unused_noise;

  assign unused_noise = ^{noise_en, noise_idx};
  assign frame_nxt    = {in_data, gen_par};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (xfer) state_nxt = FULL;
      FULL:    if (frame_ready && !xfer) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      frame_data <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) frame_data <= frame_nxt;
    end
  end

  assign new_err = chk_valid && chk_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_out_valid <= 1'b0;
      chk_out_data  <= '0;
      chk_err       <= 1'b0;
    end else begin
      chk_out_valid <= chk_valid;
      chk_err       <= new_err;
      if (chk_valid) chk_out_data <= chk_frame[FRAME_W-1:1];
    end
  end

  // Clear wins, but an error arriving in the same cycle is still recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (err_clr) begin
      err_sticky <= new_err;
      err_cnt    <= new_err ? CNT_W'(1) : '0;
    end else if (new_err) begin
      err_sticky <= 1'b1;
      if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/parity_link_gen_chk.md
PARITY_LINK_GEN_CHK -- requirements
Module: parity_link_gen_chk

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits, legal range 1..64.
REQ-002 Parameter ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 Parameter CNT_W, default 8: width of the error counter.
REQ-004 Derived constants: FRAME_W = DATA_W+1; IDX_W = $clog2(FRAME_W).
REQ-005 Port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 Port in_valid / in_ready, input / output, 1 bit each: generator input handshake.
REQ-008 Port in_data, input, DATA_W bits: payload to protect.
REQ-009 Port frame_valid / frame_ready, output / input, 1 bit each: generator output handshake.
REQ-010 Port frame_data, output, FRAME_W bits: frame {payload, parity}, parity bit at bit 0.
REQ-011 Port noise_en, input, 1 bit: request to corrupt one bit of the frame being captured.
REQ-012 Port noise_idx, input, IDX_W bits: index of the frame bit to invert.
REQ-013 Port chk_valid, input, 1 bit: received frame strobe; the checker never back-pressures.
REQ-014 Port chk_frame, input, FRAME_W bits: received frame.
REQ-015 Port chk_out_valid, output, 1 bit: checker result strobe.
REQ-016 Port chk_out_data, output, DATA_W bits: received payload, chk_frame[FRAME_W-1:1].
REQ-017 Port chk_err, output, 1 bit: parity failure for the current result.
REQ-018 Port err_sticky, output, 1 bit: latched error flag.
REQ-019 Port err_cnt, output, CNT_W bits: error count.
REQ-020 Port err_clr, input, 1 bit: clears err_sticky and err_cnt.

Function
REQ-021 Parity bit p = (^in_data) XOR ODD, so that the XOR of the full frame equals ODD.
REQ-022 The generator is a one-entry output register with state EMPTY or FULL.
REQ-023 in_ready = EMPTY OR frame_ready; a transfer occurs when in_valid and in_ready are both high.
REQ-024 A transfer captures {in_data, p} into frame_data and sets state FULL; latency is 1 cycle.
REQ-025 In FULL with frame_ready high and no new transfer, state returns to EMPTY.
REQ-026 A simultaneous drain and fill keeps state FULL with the new frame, giving full throughput.
REQ-027 frame_data and frame_valid stay stable while frame_valid is high and frame_ready is low.
REQ-028 Checker: on chk_valid, chk_out_valid is high on the next cycle, chk_out_data is registered, and chk_err = (^chk_frame) != ODD.
REQ-029 chk_out_valid is a single-cycle pulse for each chk_valid cycle.
REQ-030 On chk_err, err_sticky is set and err_cnt increments, saturating at 2^CNT_W-1 with no wrap.
REQ-031 err_clr takes precedence; if err_clr and a new error coincide, the result is err_cnt=1 and err_sticky=1.

Reset
REQ-032 While rst_n is low: state EMPTY, frame_valid=0, frame_data=0, chk_out_valid=0, chk_err=0, chk_out_data=0, err_sticky=0, err_cnt=0.
REQ-033 A reset during any operation discards the held frame and the pending check without generating any output pulse.

Configuration
REQ-034 Macro PARITY_NOISE_INJ_EN defined: on a generator transfer with noise_en=1 and noise_idx < FRAME_W, frame bit noise_idx is inverted; noise_idx >= FRAME_W injects nothing.
REQ-035 Macro PARITY_NOISE_INJ_EN undefined: noise_en and noise_idx are ignored and no injection logic is synthesised.

Structure
REQ-036 Package parity_link_pkg holds the parity-mode constants (PAR_EVEN=0, PAR_ODD=1) and the state enum (EMPTY, FULL).
REQ-037 Sub-module parity_calc, a pure combinational XOR reduction with ODD adjust, is instantiated once in the generator and once in the checker.

Verification
REQ-038 DATA_W=8, ODD=0, in_data=0xA5 -> frame_data=0x14A one cycle later; looped back to the checker -> chk_err=0.
REQ-039 ODD=1, in_data=0xA5 -> frame_data=0x14B; ODD=1, in_data=0x00 -> frame_data=0x001.
REQ-040 PARITY_NOISE_INJ_EN defined, ODD=0, 0xA5, noise_idx=0 -> frame 0x14B and chk_err=1; noise_idx=9 -> frame 0x14A unchanged.
REQ-041 Backpressure: frame_ready=0 for 5 cycles with in_valid=1 -> exactly one frame held stable and in_ready=0; on release, back-to-back frames flow one per cycle in order.
REQ-042 CNT_W=2, 5 corrupted frames -> err_cnt=3 and err_sticky=1; err_clr coinciding with an error -> err_cnt=1.
REQ-043 rst_n pulsed low while FULL -> frame_valid=0 and err_cnt=0 immediately (asynchronous), and no chk_out_valid pulse.
